// File: rtl/ppg_fifo_sched.sv
// Drains the MAX30102 sample FIFO over a byte I2C master and emits 18-bit red/IR samples.
// Define PPG_SCHED_OVF_EN to read OVF_COUNTER and treat a nonzero overflow as a full FIFO.
module ppg_fifo_sched #(
    parameter int DATA_WIDTH  = 18,
    parameter int POLL_CYCLES = 500000,
    parameter int MAX_BURST   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    output logic                  o_i2c_req,
    output logic                  o_i2c_rw,
    output logic [7:0]            o_i2c_addr,
    input  logic                  i_i2c_ack,
    input  logic [7:0]            i_i2c_rdata,
    input  logic                  i_i2c_err,
    output logic                  o_data_valid,
    output logic [DATA_WIDTH-1:0] o_red_data,
    output logic [DATA_WIDTH-1:0] o_ir_data,
    output logic                  o_busy,
    output logic [7:0]            o_err_cnt,
    output logic                  o_ovf_pulse
);
    typedef enum logic [2:0] {IDLE, RD_WP, RD_OVF, RD_RP, CALC, RD_BYTE, EMIT} state_t;
    localparam int TW = $clog2(POLL_CYCLES);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic            tick_pend_q, gap_q;
    logic [4:0]      wp_q, rp_q;
    logic [5:0]      n_q, avail, n_calc;
    logic [2:0]      byte_idx_q;
    logic [4:0][7:0] byte_q;
    logic            read_st, ack_ok, bus_err, wrap, start, last_byte;

    assign wrap      = timer_q == TW'(POLL_CYCLES - 1);
    assign start     = (state_q == IDLE) && tick_pend_q && i_enable;
    assign read_st   = state_q inside {RD_WP, RD_OVF, RD_RP, RD_BYTE};
    // gap_q holds req low for the cycle after each ack so consecutive reads are separated
    assign o_i2c_req = read_st && !gap_q;
    assign o_i2c_rw  = o_i2c_req;
    assign ack_ok    = i_i2c_ack && o_i2c_req;
    assign bus_err   = ack_ok && i_i2c_err;
    assign last_byte = byte_idx_q == 3'd5;
    assign o_busy       = state_q != IDLE;
    assign o_data_valid = state_q == EMIT;

`ifdef PPG_SCHED_OVF_EN
    localparam state_t WP_NEXT = RD_OVF;
    logic ovf_q;
    // a full FIFO has wp == rp, so only the overflow counter can tell it from empty
    assign avail       = ovf_q ? 6'd32 : {1'b0, wp_q - rp_q};
    assign o_ovf_pulse = (state_q == CALC) && ovf_q;
`else
    localparam state_t WP_NEXT = RD_RP;
    assign avail       = {1'b0, wp_q - rp_q};
    assign o_ovf_pulse = 1'b0;
`endif
    assign n_calc = (avail > 6'(MAX_BURST)) ? 6'(MAX_BURST) : avail;

    always_comb begin
        o_i2c_addr = 8'h00;
        case (state_q)
            RD_WP:   o_i2c_addr = 8'h04;
            RD_OVF:  o_i2c_addr = 8'h05;
            RD_RP:   o_i2c_addr = 8'h06;
            RD_BYTE: o_i2c_addr = 8'h07;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD_WP;
            RD_WP:   if (ack_ok) state_d = WP_NEXT;
            RD_OVF:  if (ack_ok) state_d = RD_RP;
            RD_RP:   if (ack_ok) state_d = CALC;
            CALC:    state_d = (n_calc == 6'd0) ? IDLE : RD_BYTE;
            RD_BYTE: if (ack_ok && last_byte) state_d = EMIT;
            EMIT:    state_d = (n_q == 6'd0) ? IDLE : RD_BYTE;
            default: state_d = IDLE;
        endcase
        if (bus_err) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            tick_pend_q <= 1'b0;
            gap_q       <= 1'b0;
            wp_q        <= '0;
            rp_q        <= '0;
            n_q         <= '0;
            byte_idx_q  <= '0;
            byte_q      <= '0;
            o_red_data  <= '0;
            o_ir_data   <= '0;
            o_err_cnt   <= '0;
`ifdef PPG_SCHED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            timer_q <= wrap ? '0 : timer_q + 1'b1;
            // a wrap while a tick is already pending is simply absorbed
            if (start)     tick_pend_q <= 1'b0;
            else if (wrap) tick_pend_q <= 1'b1;
            gap_q <= ack_ok;
            if (bus_err) begin
                byte_idx_q <= '0;
                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
            end else if (ack_ok) begin
                case (state_q)
                    RD_WP:  wp_q <= i_i2c_rdata[4:0];
`ifdef PPG_SCHED_OVF_EN
                    RD_OVF: ovf_q <= |i_i2c_rdata;
`endif
                    RD_RP:  rp_q <= i_i2c_rdata[4:0];
                    RD_BYTE: begin
                        if (last_byte) begin
                            o_red_data <= DATA_WIDTH'({byte_q[0], byte_q[1], byte_q[2]});
                            o_ir_data  <= DATA_WIDTH'({byte_q[3], byte_q[4], i_i2c_rdata});
                            n_q        <= n_q - 1'b1;
                            byte_idx_q <= '0;
                        end else begin
                            for (int k = 0; k < 5; k++)
                                if (byte_idx_q == 3'(k)) byte_q[k] <= i_i2c_rdata;
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (state_q == CALC) begin
                n_q        <= n_calc;
                byte_idx_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ppg_fifo_sched.sv
// Bench for ppg_fifo_sched: register-level MAX30102 model, strobe scoreboard, vector table.
module tb_ppg_fifo_sched;
    localparam int DW = 18, POLL = 64, MB = 8;
`ifdef PPG_SCHED_OVF_EN
    localparam int OVF_RD = 1;
`else
    localparam int OVF_RD = 0;
`endif

    typedef struct {
        logic [4:0] wp;
        logic [4:0] rp;
        logic [7:0] ovf;
        int np;
        int e0;
        int e1;
        int e2;
        int eovf;
        bit fixed;
    } vec_t;
    typedef struct { int red; int ir; } exp_t;

    logic clk = 1'b0;
    logic rst_n, i_enable, o_i2c_req, o_i2c_rw, i_i2c_ack, i_i2c_err;
    logic o_data_valid, o_busy, o_ovf_pulse;
    logic [7:0] o_i2c_addr, i_i2c_rdata, o_err_cnt;
    logic [DW-1:0] o_red_data, o_ir_data;

    int checks = 0, errors = 0;
    int strobes = 0, rd07 = 0, rd_total = 0, ovf_cnt = 0, polls = 0, errs = 0;
    int err_idx = -1, bis = 0, lat = 0;
    bit err_all = 0, stray = 0, busy_q = 0;
    logic [4:0] wp_reg, rp_reg;
    logic [7:0] ovf_reg;
    logic [7:0] sq[$];
    exp_t sb[$];
    vec_t vt[7];

    always #5 clk = ~clk;

    ppg_fifo_sched #(.DATA_WIDTH(DW), .POLL_CYCLES(POLL), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
        .o_i2c_req(o_i2c_req), .o_i2c_rw(o_i2c_rw), .o_i2c_addr(o_i2c_addr),
        .i_i2c_ack(i_i2c_ack), .i_i2c_rdata(i_i2c_rdata), .i_i2c_err(i_i2c_err),
        .o_data_valid(o_data_valid), .o_red_data(o_red_data), .o_ir_data(o_ir_data),
        .o_busy(o_busy), .o_err_cnt(o_err_cnt), .o_ovf_pulse(o_ovf_pulse)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic serve();
        logic [7:0] d;
        d = 8'h00;
        chk("rw_is_read", o_i2c_rw, 1);
        case (o_i2c_addr)
            8'h04: d = {3'b000, wp_reg};
            8'h05: d = ovf_reg;
            8'h06: d = {3'b000, rp_reg};
            8'h07: begin
                if (sq.size() > 0) d = sq.pop_front();
                if (rd07 == err_idx) i_i2c_err = 1'b1;
                rd07++;
                bis++;
                if (bis == 6) begin
                    bis = 0;
                    rp_reg = rp_reg + 5'd1;
                end
            end
            default: chk("addr_legal", o_i2c_addr, 8'h07);
        endcase
        if (err_all) i_i2c_err = 1'b1;
        if (i_i2c_err) errs++;
        rd_total++;
        i_i2c_rdata = d;
        i_i2c_ack = 1'b1;
    endtask

    task automatic i2c_model();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i_i2c_ack = 1'b0; i_i2c_err = 1'b0; lat = 0; bis = 0;
            end else if (i_i2c_ack) begin
                chk("req_drop_after_ack", o_i2c_req, 0);
                if (i_i2c_err) chk("abort_to_idle", o_busy, 0);
                i_i2c_ack = 1'b0; i_i2c_err = 1'b0;
                lat = $urandom_range(0, 2);
            end else if (stray && !o_i2c_req) begin
                i_i2c_ack = 1'b1; i_i2c_err = 1'b1; stray = 0;
            end else if (o_i2c_req) begin
                if (lat != 0) lat--;
                else serve();
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_data_valid === 1'b1) begin
                strobes++;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: red=0x%0h ir=0x%0h, expected no strobe", o_red_data, o_ir_data);
                end else begin
                    e = sb.pop_front();
                    chk("red_data", o_red_data, e.red);
                    chk("ir_data", o_ir_data, e.ir);
                end
            end
            if (o_ovf_pulse === 1'b1) ovf_cnt++;
            if (o_busy === 1'b1 && !busy_q) polls++;
            busy_q = (o_busy === 1'b1);
        end
    endtask

    task automatic load_sample(input bit fixed, input bit push);
        logic [7:0] b[6];
        exp_t e;
        if (fixed) begin
            b = '{8'hFF, 8'h12, 8'h34, 8'h01, 8'hAB, 8'hCD};
            e.red = 'h31234;
            e.ir  = 'h1ABCD;
        end else begin
            for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
            e.red = (int'(b[0] & 8'h03) << 16) | (int'(b[1]) << 8) | int'(b[2]);
            e.ir  = (int'(b[3] & 8'h03) << 16) | (int'(b[4]) << 8) | int'(b[5]);
        end
        for (int k = 0; k < 6; k++) sq.push_back(b[k]);
        if (push) sb.push_back(e);
    endtask

    task automatic run_poll(input string nm, input int exp_s, input int exp_r07, input int exp_ovf);
        int s0, r0, t0, o0, t;
        s0 = strobes; r0 = rd07; t0 = rd_total; o0 = ovf_cnt;
        @(negedge clk);
        i_enable = 1'b1;
        t = 0;
        while (o_busy !== 1'b1 && t < 3 * POLL) begin @(negedge clk); t++; end
        i_enable = 1'b0;
        chk({nm, "_start"}, o_busy, 1);
        t = 0;
        while (o_busy === 1'b1 && t < 4000) begin @(negedge clk); t++; end
        chk({nm, "_end"}, o_busy, 0);
        repeat (4) @(negedge clk);
        chk({nm, "_strobes"}, strobes - s0, exp_s);
        chk({nm, "_fifo_reads"}, rd07 - r0, exp_r07);
        chk({nm, "_all_reads"}, rd_total - t0, 2 + OVF_RD + exp_r07);
        chk({nm, "_ovf_pulses"}, ovf_cnt - o0, exp_ovf);
    endtask

    initial begin
        int t, p0, s0, e0;
        rst_n = 1'b0; i_enable = 1'b0;
        i_i2c_ack = 1'b0; i_i2c_err = 1'b0; i_i2c_rdata = 8'h00;
        wp_reg = '0; rp_reg = '0; ovf_reg = '0;
        fork
            i2c_model();
            monitor();
        join_none

        vt[0] = '{5'd3,  5'd1,  8'd0, 1, 2, 0, 0, 0, 1'b1};
        vt[1] = '{5'd1,  5'd30, 8'd0, 1, 3, 0, 0, 0, 1'b0};
        vt[2] = '{5'd20, 5'd0,  8'd0, 3, 8, 8, 4, 0, 1'b0};
        vt[3] = '{5'd5,  5'd5,  8'd7, 1, 8 * OVF_RD, 0, 0, OVF_RD, 1'b0};
        vt[4] = '{5'd5,  5'd5,  8'd0, 1, 0, 0, 0, 0, 1'b0};
        vt[5] = '{5'd0,  5'd31, 8'd0, 1, 1, 0, 0, 0, 1'b0};
        vt[6] = '{5'd9,  5'd1,  8'd0, 1, 8, 0, 0, 0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_req", o_i2c_req, 0);
        chk("rst_rw", o_i2c_rw, 0);
        chk("rst_addr", o_i2c_addr, 0);
        chk("rst_valid", o_data_valid, 0);
        chk("rst_red", o_red_data, 0);
        chk("rst_ir", o_ir_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err_cnt", o_err_cnt, 0);
        chk("rst_ovf", o_ovf_pulse, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            int tot;
            wp_reg = vt[i].wp; rp_reg = vt[i].rp; ovf_reg = vt[i].ovf;
            tot = vt[i].e0 + vt[i].e1 + vt[i].e2;
            for (int s = 0; s < tot; s++) load_sample(vt[i].fixed && s == 0, 1'b1);
            for (int p = 0; p < vt[i].np; p++) begin
                int ex;
                ex = (p == 0) ? vt[i].e0 : (p == 1) ? vt[i].e1 : vt[i].e2;
                run_poll($sformatf("vec%0d_poll%0d", i, p), ex, 6 * ex, (p == 0) ? vt[i].eovf : 0);
            end
            chk($sformatf("vec%0d_sb_drained", i), sb.size(), 0);
        end

        // enable held low across several ticks: one pending poll, started one cycle after enable
        wp_reg = '0; rp_reg = '0; ovf_reg = '0;
        p0 = polls;
        repeat (3 * POLL + 8) @(negedge clk);
        chk("en_low_blocks", polls - p0, 0);
        i_enable = 1'b1;
        @(negedge clk);
        chk("en_start_1cyc", o_busy, 1);
        i_enable = 1'b0;
        t = 0;
        while (o_busy === 1'b1 && t < 4000) begin @(negedge clk); t++; end
        repeat (2 * POLL) @(negedge clk);
        chk("en_single_poll", polls - p0, 1);

        // ack with err while req is low must be ignored
        stray = 1;
        repeat (5) @(negedge clk);
        chk("stray_ack_busy", o_busy, 0);
        chk("stray_ack_err_cnt", o_err_cnt, 0);

        // error on byte 4 of sample 2: one strobe, counter 1, partial sample dropped
        wp_reg = 5'd3; rp_reg = 5'd1; ovf_reg = '0;
        load_sample(1'b0, 1'b1);
        load_sample(1'b0, 1'b0);
        err_idx = rd07 + 10;
        run_poll("err_poll", 1, 11, 0);
        chk("err_cnt_one", o_err_cnt, 1);
        chk("err_sb_drained", sb.size(), 0);
        err_idx = -1;
        sq.delete();
        bis = 0;

        // repeated errors saturate the counter
        wp_reg = '0; rp_reg = '0;
        e0 = errs;
        err_all = 1;
        i_enable = 1'b1;
        t = 0;
        while (errs - e0 < 300 && t < 400 * POLL) begin @(negedge clk); t++; end
        i_enable = 1'b0;
        t = 0;
        while (o_busy === 1'b1 && t < 4000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        err_all = 0;
        chk("sat_300_errors_seen", (errs - e0 >= 300) ? 1 : 0, 1);
        chk("err_cnt_saturated", o_err_cnt, 255);

        // async reset in the middle of a FIFO byte read
        wp_reg = 5'd3; rp_reg = 5'd1;
        load_sample(1'b0, 1'b0);
        load_sample(1'b0, 1'b0);
        s0 = strobes;
        i_enable = 1'b1;
        t = 0;
        while (!(o_i2c_req === 1'b1 && o_i2c_addr == 8'h07) && t < 4 * POLL) begin
            @(negedge clk); t++;
        end
        chk("midrst_at_fifo_read", o_i2c_addr, 8'h07);
        rst_n = 1'b0;
        i_enable = 1'b0;
        #1;
        chk("midrst_req", o_i2c_req, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_err_cnt", o_err_cnt, 0);
        chk("midrst_valid", o_data_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sq.delete();
        repeat (20) @(negedge clk);
        chk("midrst_no_strobe", strobes - s0, 0);
        chk("midrst_red", o_red_data, 0);
        chk("midrst_idle", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ppg_fifo_sched.md
# ppg_fifo_sched

Sequencer that drains the MAX30102 sample FIFO over a byte-level I2C master and feeds the PPG filter/heart-rate/SpO2 pipeline. A poll timer triggers a read of the sensor's FIFO write and read pointers. The block then reads the available samples, 6 bytes each, and unpacks them into 18-bit red/IR words. Each complete sample is presented as a single-cycle valid strobe.

## Interface
- `DATA_WIDTH`, 18: width of the red/IR sample outputs (bits taken LSB-aligned from each 24-bit FIFO word).
- `POLL_CYCLES`, 500000: clk cycles between poll ticks (10 ms at 50 MHz). Must be ≥2.
- `MAX_BURST`, 8: maximum samples drained per poll (1..32).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `i_enable` in 1: high allows new polls to start. Low blocks new polls; an in-flight poll completes.
- `o_i2c_req` out 1: transaction request, held until `i_i2c_ack`.
- `o_i2c_rw` out 1: 1 = register read. This block only reads, so it is always 1 while req is high.
- `o_i2c_addr` out 8: sensor register address, stable while req is high.
- `i_i2c_ack` in 1: one-cycle completion strobe, meaningful only while req is high.
- `i_i2c_rdata` in 8: read byte, valid in the `i_i2c_ack` cycle.
- `i_i2c_err` in 1: NACK/bus error, qualified by `i_i2c_ack`.
- `o_data_valid` out 1: one-cycle sample strobe to the filter pipeline.
- `o_red_data` out DATA_WIDTH: red sample, held between strobes.
- `o_ir_data` out DATA_WIDTH: IR sample, held between strobes.
- `o_busy` out 1: high in any state other than IDLE.
- `o_err_cnt` out 8: saturating count of `i_i2c_err` events.
- `o_ovf_pulse` out 1: one-cycle strobe when the sensor reports FIFO overflow. Present only with the macro defined; tied to 0 otherwise.

## Operation
- The poll timer counts 0..POLL_CYCLES-1 and wraps. The wrap cycle sets `tick_pend`.
  - A tick arriving while `tick_pend` is already set is dropped; at most one tick is pending.
  - `tick_pend` clears when a poll starts.
- States and transitions:
  - IDLE → RD_WP when `tick_pend && i_enable`.
  - RD_WP reads addr 0x04 into `wp[4:0]`.
  - RD_WP → RD_OVF (macro defined) or RD_RP (macro undefined).
  - RD_RP reads addr 0x06 into `rp[4:0]`, then goes to CALC.
  - CALC sets `avail = (wp - rp) mod 32` and `n = min(avail, MAX_BURST)`.
  - CALC → IDLE if `n == 0`, else → RD_BYTE with `byte_idx = 0`.
  - RD_BYTE reads addr 0x07 and stores byte `byte_idx` (0..5).
  - After byte 5: go to EMIT, and decrement `n`.
  - EMIT → RD_BYTE if `n != 0`, else → IDLE.
- Every read state raises `o_i2c_req` on state entry and leaves the state on `i_i2c_ack`.
- Byte order: b0..b2 = red[23:16], red[15:8], red[7:0]; b3..b5 = IR in the same order.
  - `o_red_data = {b0[1:0], b1, b2}`.
  - `o_ir_data = {b3[1:0], b4, b5}`.
  - Bits b0[7:2] and b3[7:2] are discarded.
- Error handling: `i_i2c_ack && i_i2c_err` in any read state aborts to IDLE.
  - `o_err_cnt` increments, saturating at 255.
  - A partially assembled sample is discarded; no strobe is issued.
- Residual samples beyond MAX_BURST are drained on the next poll.

## Timing
- Reset values: every output 0; state IDLE; timer 0; `tick_pend` 0; `wp`, `rp`, `n`, `byte_idx`, and byte registers all 0.
- `o_i2c_req` rises in the first cycle of a read state.
  - It falls in the cycle after the ack is sampled.
  - Back-to-back reads therefore keep req low for at least 1 cycle between them.
- `o_data_valid` is high for exactly 1 cycle, in EMIT (the cycle after the ack of byte 5).
  - `o_red_data`/`o_ir_data` update in that same cycle.
- IDLE → RD_WP takes 1 cycle after the condition is true. `o_busy` is high from RD_WP entry until the cycle IDLE is re-entered.
- `i_enable` falling mid-poll has no effect on the current poll.
- `i_i2c_ack` while req is low is ignored.
- Asynchronous reset mid-transaction drops req immediately. No strobe is issued and the counters clear.

## Configuration
- `PPG_SCHED_OVF_EN` defined: an RD_OVF state between RD_WP and RD_RP reads addr 0x05 (OVF_COUNTER).
  - Nonzero value: CALC forces `avail = 32`, because `wp == rp` on a full FIFO, and `o_ovf_pulse` fires for 1 cycle in CALC.
- Undefined: RD_OVF is absent, `avail` is always `wp - rp` (full FIFO reads as empty), and `o_ovf_pulse` = 0.

## Test plan
- Reset, enable, and I2C model returning wp=3, rp=1 → exactly 12 reads of 0x07, then 2 `o_data_valid` pulses, then IDLE.
  - Bytes 0xFF,0x12,0x34 / 0x01,0xAB,0xCD must give red=0x31234 and ir=0x1ABCD.
- wp=1, rp=30 with MAX_BURST=8 → avail=3, 3 samples, 3 strobes; no req until the next tick.
- wp=20, rp=0 → 8 samples this poll, 8 more on the next poll, 4 on the one after.
- `i_i2c_err` on byte 4 of sample 2 → 1 strobe total, `o_err_cnt`=1, IDLE next cycle. Repeat 300 errors → `o_err_cnt` saturates at 255.
- Hold `i_enable`=0 across 3 ticks, then raise it → a single poll starts one cycle later, and only one.
- With `PPG_SCHED_OVF_EN`: wp=rp=5 and OVF=7 → `o_ovf_pulse` 1 cycle, 8 samples read. Without the macro: the same stimulus gives 0 samples.
